// File: rtl/load_store_drain.sv
// Consumer end of the load/store tank.
// Each rising edge of the loader's full flag starts one drain of N unit tokens
// over a valid/ready handshake. The remaining volume counts down to 0, a
// one-cycle empty pulse marks completion, and a sticky error flag records any
// full edge that arrives while a drain is still busy.
module load_store_drain #(
    parameter int N     = 10000,
    parameter int CBITS = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             full_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [CBITS-1:0] out_count,
    output logic             empty_pulse,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CBITS-1:0] NVOL = CBITS'(N);
    localparam logic [CBITS-1:0] ONE  = CBITS'(1);

    state_t           state;
    state_t           state_nxt;
    logic             full_q;
    logic             rise;
    logic             accept;
    logic [CBITS-1:0] count_nxt;
    logic             valid_nxt;
    logic             empty_nxt;
    logic             busy_nxt;
    logic             err_nxt;

    // A full edge is seen on any cycle where the flag is high but was low the
    // cycle before; full_q clears on reset so a flag already high at release
    // still starts a drain.
    assign rise   = full_in & ~full_q;
    assign accept = out_valid & out_ready;

    // Next-state and next-output logic; every output is registered, so this
    // block describes what the outputs will show in the following cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = out_count;
        valid_nxt = 1'b0;
        empty_nxt = 1'b0;
        busy_nxt  = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                count_nxt = '0;
                if (rise) begin
                    state_nxt = DRAIN;
                    count_nxt = NVOL;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            DRAIN: begin
                valid_nxt = 1'b1;
                busy_nxt  = 1'b1;
                if (rise) begin
                    err_nxt = 1'b1;
                end
                if (accept && (out_count >= ONE)) begin
                    if (out_count == ONE) begin
                        state_nxt = DONE;
                        count_nxt = '0;
                        valid_nxt = 1'b0;
                        empty_nxt = 1'b1;
                    end else begin
                        count_nxt = out_count - ONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                count_nxt = '0;
                if (rise) begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            full_q      <= 1'b0;
            out_count   <= '0;
            out_valid   <= 1'b0;
            empty_pulse <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            full_q      <= full_in;
            out_count   <= count_nxt;
            out_valid   <= valid_nxt;
            empty_pulse <= empty_nxt;
            busy        <= busy_nxt;
            err         <= err_nxt;
        end
    end

endmodule
